llsc_mem_ctrl: RTL and testbench

LLSC_MEM_CTRL -- requirements
Module: llsc_mem_ctrl

---
 rtl/llsc_mem_ctrl_pkg.sv | 31 +++
 rtl/llsc_mem_ctrl_if.sv | 15 +
 rtl/llsc_mem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_llsc_mem_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/llsc_mem_ctrl_pkg.sv
// Shared encodings and widths for the LL/SC memory controller.
package llsc_mem_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NONE = 3'd0,
        OP_LW   = 3'd1,
        OP_SW   = 3'd2,
        OP_LL   = 3'd3,
        OP_SC   = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_load(input op_e op);
        return (op == OP_LW) || (op == OP_LL);
    endfunction

    function automatic logic is_store(input op_e op);
        return (op == OP_SW) || (op == OP_SC);
    endfunction

endpackage

// File: rtl/llsc_mem_ctrl_if.sv
// Memory bus bundle between the LL/SC controller (master) and a memory port (slave).
interface llsc_mem_ctrl_if;
    import llsc_mem_ctrl_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);

endinterface

// File: rtl/llsc_mem_ctrl.sv
// LW/SW/LL/SC memory stage: one op at a time via IDLE->REQ->DONE; optional LLSC_ADDR_CHECK_EN adds a link-address check.
// Latency: result in DONE two cycles after acceptance with a zero-wait ack; failing SC skips the bus (one cycle).
// Backpressure: stallreq_o holds the pipeline from acceptance until DONE; bus request held until mem_ack_i.
module llsc_mem_ctrl
    import llsc_mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_W-1:0]  wd_i,
    input  logic              llbit_i,
    input  logic              wb_llbit_we_i,
    input  logic              wb_llbit_value_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stallreq_o,
    output logic              wreg_o,
    output logic [REG_W-1:0]  wd_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              llbit_we_o,
    output logic              llbit_value_o
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [REG_W-1:0]  wd_q, wd_d;
    logic [DATA_W-1:0] res_q, res_d;
`ifdef LLSC_ADDR_CHECK_EN
    logic [ADDR_W-3:0] link_addr_q, link_addr_d;
`endif

    logic llbit_eff;
    logic link_ok;
    logic accept;
    logic in_req;
    logic in_done;
    logic wr;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wd_d    = wd_q;
        res_d   = res_q;
`ifdef LLSC_ADDR_CHECK_EN
        link_addr_d = link_addr_q;
`endif

        // An LLbit write still in flight downstream is newer than the register copy.
        llbit_eff = wb_llbit_we_i ? wb_llbit_value_i : llbit_i;
`ifdef LLSC_ADDR_CHECK_EN
        link_ok = llbit_eff && (addr_i[ADDR_W-1:2] == link_addr_q);
`else
        link_ok = llbit_eff;
`endif
        accept = (state_q == S_IDLE) && valid_i && (op_i != OP_NONE) && !flush;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = op_e'(op_i);
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    wd_d    = wd_i;
                    res_d   = '0;
                    if ((op_e'(op_i) == OP_SC) && !link_ok) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack_i) begin
                    if (is_load(op_q)) begin
                        res_d = mem_rdata_i;
                    end else if (op_q == OP_SC) begin
                        res_d = 32'd1;
                    end else begin
                        res_d = '0;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef LLSC_ADDR_CHECK_EN
                if (op_q == OP_LL) begin
                    link_addr_d = addr_q[ADDR_W-1:2];
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over ack and acceptance; the link address is architectural and survives.
        if (flush) begin
            state_d = S_IDLE;
            op_d    = OP_NONE;
            addr_d  = '0;
            wdata_d = '0;
            wd_d    = '0;
            res_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            wd_q    <= '0;
            res_q   <= '0;
`ifdef LLSC_ADDR_CHECK_EN
            link_addr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wd_q    <= wd_d;
            res_q   <= res_d;
`ifdef LLSC_ADDR_CHECK_EN
            link_addr_q <= link_addr_d;
`endif
        end
    end

    assign in_req  = (state_q == S_REQ);
    assign in_done = (state_q == S_DONE);
    assign wr      = in_done && (is_load(op_q) || (op_q == OP_SC));

    assign stallreq_o  = accept || in_req;
    assign mem_req_o   = in_req;
    assign mem_we_o    = in_req && is_store(op_q);
    assign mem_addr_o  = in_req ? addr_q : '0;
    assign mem_wdata_o = in_req ? wdata_q : '0;

    assign wreg_o  = wr;
    assign wd_o    = wr ? wd_q : '0;
    assign wdata_o = wr ? res_q : '0;

`ifdef LLSC_ADDR_CHECK_EN
    // A completed plain store to the linked word breaks the reservation.
    assign llbit_we_o = in_done && ((op_q == OP_LL) || (op_q == OP_SC) ||
                                    ((op_q == OP_SW) && (addr_q[ADDR_W-1:2] == link_addr_q)));
`else
    assign llbit_we_o = in_done && ((op_q == OP_LL) || (op_q == OP_SC));
`endif
    assign llbit_value_o = in_done && (op_q == OP_LL);

endmodule

// File: tb/tb_llsc_mem_ctrl.sv
// Directed bench for llsc_mem_ctrl: vector table for single ops plus flush/reset/link-address sequences.
module tb_llsc_mem_ctrl;
    import llsc_mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid_i;
    logic [2:0]  op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [4:0]  wd_i;
    logic        llbit_i;
    logic        wb_llbit_we_i;
    logic        wb_llbit_value_i;
    logic        stallreq_o;
    logic        wreg_o;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o;
    logic        llbit_we_o;
    logic        llbit_value_o;

    int checks = 0;
    int errors = 0;

    llsc_mem_ctrl_if bus ();

    always #5 clk = ~clk;

    llsc_mem_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .valid_i          (valid_i),
        .op_i             (op_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .wd_i             (wd_i),
        .llbit_i          (llbit_i),
        .wb_llbit_we_i    (wb_llbit_we_i),
        .wb_llbit_value_i (wb_llbit_value_i),
        .mem_req_o        (bus.mem_req),
        .mem_we_o         (bus.mem_we),
        .mem_addr_o       (bus.mem_addr),
        .mem_wdata_o      (bus.mem_wdata),
        .mem_ack_i        (bus.mem_ack),
        .mem_rdata_i      (bus.mem_rdata),
        .stallreq_o       (stallreq_o),
        .wreg_o           (wreg_o),
        .wd_o             (wd_o),
        .wdata_o          (wdata_o),
        .llbit_we_o       (llbit_we_o),
        .llbit_value_o    (llbit_value_o)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  wd;
        logic        llbit;
        logic        wb_we;
        logic        wb_val;
        int          ack_wait;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_bwe;
        int          e_stall;
        logic        e_wreg;
        logic [4:0]  e_wd;
        logic [31:0] e_wdata;
        logic        e_llwe;
        logic        e_llval;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one op, plays the memory slave with the given ack delay, checks bus, stall and DONE outputs.
    task automatic run_vec(input string tag, input vec_t v);
        int          stall_cnt = 0;
        int          req_cnt   = 0;
        logic        seen_req  = 1'b0;
        logic        seen_we   = 1'b0;
        logic        done      = 1'b0;
        logic [31:0] seen_addr = 32'h0;
        logic [31:0] seen_wd   = 32'h0;
        @(negedge clk);
        valid_i = 1'b1; op_i = v.op; addr_i = v.addr; wdata_i = v.wdata; wd_i = v.wd;
        llbit_i = v.llbit; wb_llbit_we_i = v.wb_we; wb_llbit_value_i = v.wb_val;
        #1;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            if (cyc > 0 && !stallreq_o) begin
                done = 1'b1;
                chk({tag, "_wreg"}, {31'h0, wreg_o}, {31'h0, v.e_wreg});
                chk({tag, "_wd"}, {27'h0, wd_o}, {27'h0, v.e_wd});
                chk({tag, "_wdata"}, wdata_o, v.e_wdata);
                chk({tag, "_llwe"}, {31'h0, llbit_we_o}, {31'h0, v.e_llwe});
                chk({tag, "_llval"}, {31'h0, llbit_value_o}, {31'h0, v.e_llval});
                valid_i = 1'b0; op_i = 3'd0;
            end else begin
                if (stallreq_o) stall_cnt++;
                if (bus.mem_req) begin
                    seen_req  = 1'b1;
                    seen_we   = bus.mem_we;
                    seen_addr = bus.mem_addr;
                    seen_wd   = bus.mem_wdata;
                    bus.mem_ack   = (req_cnt == v.ack_wait);
                    bus.mem_rdata = bus.mem_ack ? v.rdata : 32'hA5A5A5A5;
                    req_cnt++;
                end
                @(negedge clk);
                wb_llbit_we_i = 1'b0; bus.mem_ack = 1'b0;
                #1;
            end
        end
        chk({tag, "_done"}, {31'h0, done}, 32'h1);
        chk({tag, "_stall_cycles"}, stall_cnt, v.e_stall);
        chk({tag, "_bus_req"}, {31'h0, seen_req}, {31'h0, v.e_req});
        chk({tag, "_bus_we"}, {31'h0, seen_we}, {31'h0, v.e_bwe});
        chk({tag, "_bus_addr"}, seen_addr, v.e_req ? v.addr : 32'h0);
        chk({tag, "_bus_wdata"}, seen_wd, v.e_req ? v.wdata : 32'h0);
        valid_i = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, "_back_idle"}, {28'h0, stallreq_o, wreg_o, llbit_we_o, bus.mem_req}, 32'h0);
    endtask

    initial begin
        //          op     addr          wdata         wd    llb   wbwe  wbv   aw rdata          req   bwe   st wreg  ewd   ewdata        llwe  llval
        tbl[0] = '{OP_LW, 32'h0000_0040, 32'h0,        5'd3, 1'b0, 1'b0, 1'b0, 0, 32'h1234_5678, 1'b1, 1'b0, 2, 1'b1, 5'd3, 32'h1234_5678, 1'b0, 1'b0};
        tbl[1] = '{OP_LL, 32'h0000_0100, 32'h0,        5'd7, 1'b0, 1'b0, 1'b0, 1, 32'hDEAD_BEEF, 1'b1, 1'b0, 3, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b1};
        tbl[2] = '{OP_SW, 32'h0000_0200, 32'hCAFE_F00D, 5'd9, 1'b1, 1'b0, 1'b0, 2, 32'h0,        1'b1, 1'b1, 4, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0};
        tbl[3] = '{OP_SC, 32'h0000_0100, 32'h5,        5'd4, 1'b1, 1'b0, 1'b0, 0, 32'h0,        1'b1, 1'b1, 2, 1'b1, 5'd4, 32'h1,         1'b1, 1'b0};
        tbl[4] = '{OP_SC, 32'h0000_0100, 32'h6,        5'd5, 1'b1, 1'b1, 1'b0, 0, 32'h0,        1'b0, 1'b0, 1, 1'b1, 5'd5, 32'h0,         1'b1, 1'b0};
        tbl[5] = '{OP_SC, 32'h0000_0102, 32'h7,        5'd6, 1'b0, 1'b1, 1'b1, 1, 32'h0,        1'b1, 1'b1, 3, 1'b1, 5'd6, 32'h1,         1'b1, 1'b0};
        tbl[6] = '{OP_SC, 32'h0000_0100, 32'h8,        5'd8, 1'b0, 1'b0, 1'b0, 0, 32'h0,        1'b0, 1'b0, 1, 1'b1, 5'd8, 32'h0,         1'b1, 1'b0};

        rst = 1'b0; flush = 1'b0; valid_i = 1'b0; op_i = 3'd0; addr_i = 32'h0; wdata_i = 32'h0;
        wd_i = 5'd0; llbit_i = 1'b0; wb_llbit_we_i = 1'b0; wb_llbit_value_i = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctrl", {26'h0, bus.mem_req, bus.mem_we, stallreq_o, wreg_o, llbit_we_o, llbit_value_o}, 32'h0);
        chk("reset_addr", bus.mem_addr, 32'h0);
        chk("reset_wdata", wdata_o, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Flush in REQ together with an ack: flush must win and no result may appear.
        @(negedge clk);
        valid_i = 1'b1; op_i = OP_LW; addr_i = 32'h80; wd_i = 5'd2;
        #1;
        chk("flush_accept_stall", {31'h0, stallreq_o}, 32'h1);
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        chk("flush_in_req", {31'h0, bus.mem_req}, 32'h1);
        flush = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_1111;
        @(negedge clk);
        flush = 1'b0; bus.mem_ack = 1'b0;
        #1;
        chk("flush_next_idle", {28'h0, bus.mem_req, stallreq_o, wreg_o, llbit_we_o}, 32'h0);
        @(negedge clk);
        #1;
        chk("flush_no_late_pulse", {30'h0, wreg_o, llbit_we_o}, 32'h0);

        // Reset mid-REQ of a store with nonzero address/data.
        @(negedge clk);
        valid_i = 1'b1; op_i = OP_SW; addr_i = 32'h300; wdata_i = 32'hFFFF; wd_i = 5'd1;
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        chk("rst_pre_addr", bus.mem_addr, 32'h300);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_ctrl", {26'h0, bus.mem_req, bus.mem_we, stallreq_o, wreg_o, llbit_we_o, llbit_value_o}, 32'h0);
        chk("rst_bus_addr", bus.mem_addr, 32'h0);
        chk("rst_bus_wdata", bus.mem_wdata, 32'h0);
        chk("rst_result", {wd_o, wdata_o[26:0]}, 32'h0);
        rst = 1'b1;

`ifdef LLSC_ADDR_CHECK_EN
        begin
            vec_t v;
            v = '{OP_LL, 32'h100, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 0, 32'h55, 1'b1, 1'b0, 2, 1'b1, 5'd3, 32'h55, 1'b1, 1'b1};
            run_vec("ac_ll", v);
            v = '{OP_SC, 32'h104, 32'h9, 5'd4, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1, 1'b1, 5'd4, 32'h0, 1'b1, 1'b0};
            run_vec("ac_sc_other_word", v);
            v = '{OP_SC, 32'h100, 32'hA, 5'd5, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b1, 2, 1'b1, 5'd5, 32'h1, 1'b1, 1'b0};
            run_vec("ac_sc_same_word", v);
            v = '{OP_SW, 32'h101, 32'hB, 5'd6, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b1, 2, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0};
            run_vec("ac_sw_linked", v);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
